// File: rtl/ddr4_cmd_decoder_pkg.sv
// Shared types for the DDR4 command decoder.
// Holds the power-state and command enums, the strobe payload structs,
// default widths and the pin-to-command decode function.
package ddr4_cmd_pkg;

  localparam int unsigned BG_W      = 2;
  localparam int unsigned BA_W      = 2;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned COL_W     = 10;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  typedef enum logic [1:0] {
    PWR_INIT    = 2'd0,
    PWR_ACTIVE  = 2'd1,
    PWR_PWRDN   = 2'd2,
    PWR_SELFREF = 2'd3
  } pwr_state_e;

  typedef enum logic [3:0] {
    CMD_DES  = 4'd0,
    CMD_NOP  = 4'd1,
    CMD_ACT  = 4'd2,
    CMD_MRS  = 4'd3,
    CMD_REF  = 4'd4,
    CMD_PRE  = 4'd5,
    CMD_PREA = 4'd6,
    CMD_WR   = 4'd7,
    CMD_WRA  = 4'd8,
    CMD_RD   = 4'd9,
    CMD_RDA  = 4'd10,
    CMD_ZQC  = 4'd11,
    CMD_RFU  = 4'd12
  } cmd_e;

  // Command strobes produced by the decode path.
  typedef struct packed {
    logic act;
    logic mrw;
    logic rfsh;
    logic pr;
    logic pra;
    logic wr;
    logic wra;
    logic rd;
    logic rda;
    logic cfg;
  } cmd_strb_t;

  // CKE-driven power strobes produced by the power FSM.
  typedef struct packed {
    logic ckeh;
    logic ckel;
    logic pd;
    logic pdx;
    logic srf;
  } pwr_strb_t;

  // Classify one sample of the command pins; a10 selects AP / all-banks.
  function automatic cmd_e decode_cmd(input logic cs_n, input logic act_n,
                                      input logic ras_n, input logic cas_n,
                                      input logic we_n, input logic a10);
    cmd_e cmd;
    cmd = CMD_NOP;
    if (cs_n) begin
      cmd = CMD_DES;
    end else if (!act_n) begin
      cmd = CMD_ACT;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b000: cmd = CMD_MRS;
        3'b001: cmd = CMD_REF;
        3'b010: cmd = a10 ? CMD_PREA : CMD_PRE;
        3'b011: cmd = CMD_RFU;
        3'b100: cmd = a10 ? CMD_WRA : CMD_WR;
        3'b101: cmd = a10 ? CMD_RDA : CMD_RD;
        3'b110: cmd = CMD_ZQC;
        3'b111: cmd = CMD_NOP;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/ddr4_cmd_decoder_if.sv
// DDR4 command/address pin bundle.
// master: controller side driving the pins; slave: decoder sampling them.
// Signals: cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, a.
interface ddr4_cmd_if
  import ddr4_cmd_pkg::*;
#(
  parameter int unsigned BGWIDTH   = BG_W,
  parameter int unsigned BAWIDTH   = BA_W,
  parameter int unsigned ADDRWIDTH = ADDR_W
);

  logic                 cke;
  logic                 cs_n;
  logic                 act_n;
  logic                 ras_n;
  logic                 cas_n;
  logic                 we_n;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic [ADDRWIDTH-1:0] a;

  modport master (output cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, a);
  modport slave  (input  cke, cs_n, act_n, ras_n, cas_n, we_n, bg, ba, a);

endinterface

// File: rtl/ddr4_cmd_decoder_cke_pwr_fsm.sv
// CKE tracking and power-state FSM.
// Ports: clk, rst (sync, active-high), cke_i, cmd_i (decoded pins),
//   state_o (registered power state), strb_o (registered CKEH/CKEL/PD/PDX/SRF),
//   decode_en_c (pins may be decoded this cycle),
//   drop_cmd_c (a real command arrived with CKE falling and is dropped).
module cke_pwr_fsm
  import ddr4_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cke_i,
  input  cmd_e       cmd_i,
  output pwr_state_e state_o,
  output pwr_strb_t  strb_o,
  output logic       decode_en_c,
  output logic       drop_cmd_c
);

  pwr_state_e state_q, state_d;
  pwr_strb_t  strb_q, strb_d;
  logic       cke_q;

  // State, previous-CKE and power strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWR_INIT;
      strb_q  <= '0;
      cke_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      cke_q   <= cke_i;
    end
  end

  // Next state and power strobes; a CKE transition outranks command decode.
  always_comb begin
    state_d     = state_q;
    strb_d      = '0;
    decode_en_c = 1'b0;
    drop_cmd_c  = 1'b0;
    case (state_q)
      PWR_INIT: begin
        if (cke_i) begin
          strb_d.ckeh = 1'b1;
          state_d     = PWR_ACTIVE;
        end
      end
      PWR_ACTIVE: begin
        if (cke_q) begin
          if (cke_i) begin
            decode_en_c = 1'b1;
          end else begin
            strb_d.ckel = 1'b1;
            if (cmd_i == CMD_REF) begin
              strb_d.srf = 1'b1;
              state_d    = PWR_SELFREF;
            end else begin
              strb_d.pd  = 1'b1;
              state_d    = PWR_PWRDN;
              drop_cmd_c = (cmd_i != CMD_DES) && (cmd_i != CMD_NOP);
            end
          end
        end
      end
      PWR_PWRDN: begin
        if (cke_i) begin
          strb_d.pdx  = 1'b1;
          strb_d.ckeh = 1'b1;
          state_d     = PWR_ACTIVE;
        end
      end
      PWR_SELFREF: begin
        if (cke_i) begin
          strb_d.ckeh = 1'b1;
          state_d     = PWR_ACTIVE;
        end
      end
      default: state_d = PWR_INIT;
    endcase
  end

  assign state_o = state_q;
  assign strb_o  = strb_q;

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command/address decoder for the memory-side model.
// Ports: clk, rst (sync, active-high), cmd (pin bundle, slave side),
//   bg_q/ba_q/row_q/col_q (registered address latches),
//   ACT..WRA (one-cycle command and power strobes), illegal (one-cycle pulse),
//   err_cnt (saturating illegal count), pwr_state (current power state).
// All outputs appear one clock after the pins are sampled.
module ddr4_cmd_decoder
  import ddr4_cmd_pkg::*;
#(
  parameter int unsigned BGWIDTH   = BG_W,
  parameter int unsigned BAWIDTH   = BA_W,
  parameter int unsigned ADDRWIDTH = ADDR_W,
  parameter int unsigned COLWIDTH  = COL_W
)(
  input  logic                 clk,
  input  logic                 rst,
  ddr4_cmd_if.slave            cmd,
  output logic [BGWIDTH-1:0]   bg_q,
  output logic [BAWIDTH-1:0]   ba_q,
  output logic [ADDRWIDTH-1:0] row_q,
  output logic [COLWIDTH-1:0]  col_q,
  output logic                 ACT,
  output logic                 BST,
  output logic                 CFG,
  output logic                 CKEH,
  output logic                 CKEL,
  output logic                 DPD,
  output logic                 DPDX,
  output logic                 MRR,
  output logic                 MRW,
  output logic                 PD,
  output logic                 PDX,
  output logic                 PR,
  output logic                 PRA,
  output logic                 RD,
  output logic                 RDA,
  output logic                 REF,
  output logic                 SRF,
  output logic                 WR,
  output logic                 WRA,
  output logic                 illegal,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           pwr_state
);

  cmd_e                 cmd_c;
  pwr_state_e           pwr_state_s;
  pwr_strb_t            pwr_strb;
  logic                 decode_en_c;
  logic                 drop_cmd_c;
  cmd_strb_t            strb_q, strb_d;
  logic                 illegal_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic [BGWIDTH-1:0]   bg_d;
  logic [BAWIDTH-1:0]   ba_d;
  logic [ADDRWIDTH-1:0] row_d;
  logic [COLWIDTH-1:0]  col_d;
  logic                 unused_addr_bits;

  assign cmd_c = decode_cmd(cmd.cs_n, cmd.act_n, cmd.ras_n, cmd.cas_n,
                            cmd.we_n, cmd.a[10]);

  // Only a[13:0] ever reaches an output; the upper pins are sampled but dropped.
  assign unused_addr_bits = ^cmd.a;

  cke_pwr_fsm u_pwr_fsm (
    .clk         (clk),
    .rst         (rst),
    .cke_i       (cmd.cke),
    .cmd_i       (cmd_c),
    .state_o     (pwr_state_s),
    .strb_o      (pwr_strb),
    .decode_en_c (decode_en_c),
    .drop_cmd_c  (drop_cmd_c)
  );

  // Command strobes, address latches and illegal accounting.
  always_comb begin
    strb_d    = '0;
    illegal_d = drop_cmd_c;
    err_cnt_d = err_cnt;
    bg_d      = bg_q;
    ba_d      = ba_q;
    row_d     = row_q;
    col_d     = col_q;
    if (decode_en_c) begin
      case (cmd_c)
        CMD_ACT: begin
          strb_d.act = 1'b1;
          // During ACT the ras/cas/we pins carry A16/A15/A14.
          row_d = ADDRWIDTH'({cmd.ras_n, cmd.cas_n, cmd.we_n, cmd.a[13:0]});
        end
        CMD_MRS:  strb_d.mrw  = 1'b1;
        CMD_REF:  strb_d.rfsh = 1'b1;
        CMD_PRE:  strb_d.pr   = 1'b1;
        CMD_PREA: strb_d.pra  = 1'b1;
        CMD_WR: begin
          strb_d.wr = 1'b1;
          col_d     = cmd.a[COLWIDTH-1:0];
        end
        CMD_WRA: begin
          strb_d.wra = 1'b1;
          col_d      = cmd.a[COLWIDTH-1:0];
        end
        CMD_RD: begin
          strb_d.rd = 1'b1;
          col_d     = cmd.a[COLWIDTH-1:0];
        end
        CMD_RDA: begin
          strb_d.rda = 1'b1;
          col_d      = cmd.a[COLWIDTH-1:0];
        end
        CMD_ZQC:  strb_d.cfg  = 1'b1;
        CMD_RFU:  illegal_d   = 1'b1;
        default:  ;
      endcase
      // Bank address follows every strobed command so it stays aligned.
      if (|strb_d) begin
        bg_d = BGWIDTH'(cmd.bg);
        ba_d = BAWIDTH'(cmd.ba);
      end
    end
    if (illegal_d && (err_cnt != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strb_q  <= '0;
      illegal <= 1'b0;
      err_cnt <= '0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      strb_q  <= strb_d;
      illegal <= illegal_d;
      err_cnt <= err_cnt_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign ACT  = strb_q.act;
  assign MRW  = strb_q.mrw;
  assign REF  = strb_q.rfsh;
  assign PR   = strb_q.pr;
  assign PRA  = strb_q.pra;
  assign WR   = strb_q.wr;
  assign WRA  = strb_q.wra;
  assign RD   = strb_q.rd;
  assign RDA  = strb_q.rda;
  assign CFG  = strb_q.cfg;
  assign CKEH = pwr_strb.ckeh;
  assign CKEL = pwr_strb.ckel;
  assign PD   = pwr_strb.pd;
  assign PDX  = pwr_strb.pdx;
  assign SRF  = pwr_strb.srf;

  // LPDDR-only commands never occur on a DDR4 bus.
  assign BST  = 1'b0;
  assign DPD  = 1'b0;
  assign DPDX = 1'b0;
  assign MRR  = 1'b0;

  assign pwr_state = pwr_state_s;

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Scoreboard bench for ddr4_cmd_decoder: a behavioural model predicts each
// cycle's outputs when pins are driven; predictions are popped and compared
// one clock later.
module tb_ddr4_cmd_decoder;
  import ddr4_cmd_pkg::*;

  localparam int unsigned BGW = 2;
  localparam int unsigned BAW = 2;
  localparam int unsigned AW  = 17;
  localparam int unsigned CW  = 10;

  // Bit positions inside the 19-bit strobe vector (port-list order).
  localparam int B_ACT = 18, B_BST = 17, B_CFG = 16, B_CKEH = 15, B_CKEL = 14;
  localparam int B_DPD = 13, B_DPDX = 12, B_MRR = 11, B_MRW = 10, B_PD = 9;
  localparam int B_PDX = 8, B_PR = 7, B_PRA = 6, B_RD = 5, B_RDA = 4;
  localparam int B_REF = 3, B_SRF = 2, B_WR = 1, B_WRA = 0;

  typedef struct {
    logic [18:0]    strb;
    logic           ill;
    logic [7:0]     err;
    logic [1:0]     pwr;
    logic [BGW-1:0] bg;
    logic [BAW-1:0] ba;
    logic [AW-1:0]  row;
    logic [CW-1:0]  col;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr4_cmd_if #(.BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW)) pins ();

  logic [BGW-1:0] bg_q;
  logic [BAW-1:0] ba_q;
  logic [AW-1:0]  row_q;
  logic [CW-1:0]  col_q;
  logic ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA;
  logic RD, RDA, REF, SRF, WR, WRA, illegal;
  logic [7:0] err_cnt;
  logic [1:0] pwr_state;

  ddr4_cmd_decoder #(.BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cmd(pins),
    .bg_q(bg_q), .ba_q(ba_q), .row_q(row_q), .col_q(col_q),
    .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL), .DPD(DPD),
    .DPDX(DPDX), .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX), .PR(PR), .PRA(PRA),
    .RD(RD), .RDA(RDA), .REF(REF), .SRF(SRF), .WR(WR), .WRA(WRA),
    .illegal(illegal), .err_cnt(err_cnt), .pwr_state(pwr_state)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Model state.
  int             m_state = 0;
  logic           m_cke_q = 1'b0;
  logic [7:0]     m_err = '0;
  logic [BGW-1:0] m_bg = '0;
  logic [BAW-1:0] m_ba = '0;
  logic [AW-1:0]  m_row = '0;
  logic [CW-1:0]  m_col = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [18:0] dut_strb();
    return {ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA,
            RD, RDA, REF, SRF, WR, WRA};
  endfunction

  // Predict the outputs that the currently driven pins produce after the next edge.
  task automatic predict();
    exp_t        e;
    logic [18:0] s;
    logic        ill;
    logic [2:0]  rcw;
    logic [AW-1:0] av;
    s   = '0;
    ill = 1'b0;
    rcw = {pins.ras_n, pins.cas_n, pins.we_n};
    av  = pins.a;
    if (rst) begin
      m_state = 0; m_cke_q = 1'b0; m_err = '0;
      m_bg = '0; m_ba = '0; m_row = '0; m_col = '0;
    end else begin
      case (m_state)
        0: if (pins.cke) begin s[B_CKEH] = 1'b1; m_state = 1; end
        1: begin
          if (m_cke_q && !pins.cke) begin
            s[B_CKEL] = 1'b1;
            if (!pins.cs_n && pins.act_n && rcw == 3'b001) begin
              s[B_SRF] = 1'b1; m_state = 3;
            end else begin
              s[B_PD] = 1'b1; m_state = 2;
              if (!pins.cs_n && !(pins.act_n && rcw == 3'b111)) ill = 1'b1;
            end
          end else if (m_cke_q && pins.cke && !pins.cs_n) begin
            if (!pins.act_n) begin
              s[B_ACT] = 1'b1;
              m_row = {rcw, av[13:0]};
            end else begin
              case (rcw)
                3'b000: s[B_MRW] = 1'b1;
                3'b001: s[B_REF] = 1'b1;
                3'b010: if (av[10]) s[B_PRA] = 1'b1; else s[B_PR] = 1'b1;
                3'b011: ill = 1'b1;
                3'b100: begin
                  if (av[10]) s[B_WRA] = 1'b1; else s[B_WR] = 1'b1;
                  m_col = av[CW-1:0];
                end
                3'b101: begin
                  if (av[10]) s[B_RDA] = 1'b1; else s[B_RD] = 1'b1;
                  m_col = av[CW-1:0];
                end
                3'b110: s[B_CFG] = 1'b1;
                default: ;
              endcase
            end
            if (s != '0) begin m_bg = pins.bg; m_ba = pins.ba; end
          end
        end
        2: if (pins.cke) begin s[B_PDX] = 1'b1; s[B_CKEH] = 1'b1; m_state = 1; end
        3: if (pins.cke) begin s[B_CKEH] = 1'b1; m_state = 1; end
        default: m_state = 0;
      endcase
      m_cke_q = pins.cke;
      if (ill && m_err != 8'hFF) m_err = m_err + 8'd1;
    end
    e.strb = s; e.ill = ill; e.err = m_err; e.pwr = 2'(m_state);
    e.bg = m_bg; e.ba = m_ba; e.row = m_row; e.col = m_col;
    sb.push_back(e);
  endtask

  // One clock: predict, advance, pop and compare.
  task automatic step();
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("strobes", 32'(dut_strb()), 32'(e.strb));
      check("illegal", 32'(illegal), 32'(e.ill));
      check("err_cnt", 32'(err_cnt), 32'(e.err));
      check("pwr_state", 32'(pwr_state), 32'(e.pwr));
      check("bg_q", 32'(bg_q), 32'(e.bg));
      check("ba_q", 32'(ba_q), 32'(e.ba));
      check("row_q", 32'(row_q), 32'(e.row));
      check("col_q", 32'(col_q), 32'(e.col));
    end
  endtask

  task automatic drive(input logic r, input logic ck, input logic cs, input logic act,
                       input logic [2:0] rcw, input logic [BGW-1:0] g,
                       input logic [BAW-1:0] b, input logic [AW-1:0] addr);
    rst        = r;
    pins.cke   = ck;
    pins.cs_n  = cs;
    pins.act_n = act;
    {pins.ras_n, pins.cas_n, pins.we_n} = rcw;
    pins.bg    = g;
    pins.ba    = b;
    pins.a     = addr;
    step();
  endtask

  initial begin
    int pulses;
    // Reset, held across a cke=1 cycle.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b111, '0, '0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, '0, '0, '0);
    check("rst_pwr_init", 32'(pwr_state), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b111, '0, '0, '0);
    check("init_ckeh", 32'(CKEH), 32'd1);

    // ACT row/bank latch.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 2'd2, 2'd1, 17'h02BCD);
    check("act_strobe", 32'(ACT), 32'd1);
    check("act_row", 32'(row_q), 32'h1ABCD);
    check("act_bank", 32'({bg_q, ba_q}), 32'h9);

    // RDA then WR back to back.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b101, 2'd0, 2'd3, 17'h00555);
    check("rda_strobe", 32'(RDA), 32'd1);
    check("rda_col", 32'(col_q), 32'h155);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 2'd1, 2'd2, 17'h000AA);
    check("wr_strobe", 32'(WR), 32'd1);

    // Every ras/cas/we code with both a10 values, plus DES.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'(i % 8), 2'(i), 2'(i / 4),
            17'((i / 8) << 10) | 17'(i * 37));
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 2'd3, 2'd3, 17'h1FFFF);

    // Self-refresh entry, blocked ACT, exit.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 2'd1, 2'd1, '0);
    check("sr_entry_pwr", 32'(pwr_state), 32'd3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 2'd2, 2'd2, 17'h00123);
    check("sr_act_blocked", 32'(ACT), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 2'd2, 2'd2, 17'h00123);
    check("sr_exit_ckeh", 32'({CKEH, PDX, ACT}), 32'b100);

    // Power-down via NOP, then a WR dropped on CKE fall.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b111, '0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, '0, '0, '0);
    check("pd_entry", 32'({PD, CKEL}), 32'b11);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b111, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b111, '0, '0, '0);
    check("pd_exit", 32'({PDX, CKEH}), 32'b11);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b111, '0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 2'd3, 2'd0, 17'h00011);
    check("wr_drop", 32'({PD, CKEL, illegal, WR}), 32'b1110);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b111, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b111, '0, '0, '0);

    // 300 RFU commands: one pulse each, counter saturates.
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b011, 2'(i), 2'(i), 17'(i));
      if (illegal) pulses++;
    end
    check("rfu_pulses", 32'(pulses), 32'd300);
    check("err_saturated", 32'(err_cnt), 32'd255);

    // Random traffic, mostly with CKE high.
    for (int i = 0; i < 80; i++) begin
      drive(1'b0, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
            2'($urandom), 2'($urandom), 17'($urandom));
    end

    // Return to ACTIVE, enter self-refresh, reset with a REF on the pins.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b111, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b111, '0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 2'd2, 2'd3, '0);
    check("sr_before_rst", 32'(pwr_state), 32'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 2'd2, 2'd3, '0);
    check("rst_strobes", 32'({dut_strb(), illegal}), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 2'd2, 2'd3, '0);
    check("post_rst_ckeh", 32'({CKEH, REF, pwr_state}), 32'b1001);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 2'd2, 2'd3, '0);
    check("post_rst_ref", 32'(REF), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
